// File: rtl/matrixa_job_arbiter.sv
`timescale 1ns/1ps
// Round-robin owner arbitration for one shared HLS matrixa core (ap_ctrl_hs).
// Grants one requester at a time, drives ap_start and returns ap_done as a done pulse.
module matrixa_job_arbiter #(
   parameter int NREQ    = 4,
   parameter int DW      = 64,
   parameter int CW      = 16,
   parameter int TIMEOUT = 4096
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DW-1:0]   req_desc,
   output logic [NREQ-1:0]      grant,
   output logic [NREQ-1:0]      done,
   output logic                 core_ap_start,
   input  logic                 core_ap_ready,
   input  logic                 core_ap_done,
   output logic [DW-1:0]        core_desc,
   output logic                 busy,
   output logic [CW-1:0]        last_latency,
   output logic                 timeout_err
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [CW-1:0] LAT_MAX = '1;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      RUN,
      DONE
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   owner;
   logic [PW-1:0]   pick_idx;
   logic            pick_valid;
   logic [CW-1:0]   lat_cnt;
   logic [CW-1:0]   run_cnt;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == LAT_MAX) ? v : v + 1'b1;
   endfunction

   // Scan from the highest offset down so the lowest offset from rr_ptr wins.
   always_comb begin : arb
      logic [PW:0] slot;
      // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
      pick_valid = 1'b0;
      pick_idx   = '0;
      slot       = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         slot = {1'b0, rr_ptr} + (PW+1)'(i);
         if (slot >= (PW+1)'(NREQ)) begin
            slot = slot - (PW+1)'(NREQ);
         end
         if (req[slot[PW-1:0]]) begin
            pick_valid = 1'b1;
            pick_idx   = slot[PW-1:0];
         end
      end
   end

   always_comb begin : next_state
      state_nxt = state;
      unique case (state)
         IDLE:    if (pick_valid) state_nxt = START;
         START:   if (core_ap_ready) state_nxt = core_ap_done ? DONE : RUN;
         RUN:     if (core_ap_done) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin : outputs
      core_ap_start = (state == START);
      busy          = (state != IDLE);
      done          = (state == DONE) ? grant : '0;
   end

   // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         grant        <= '0;
         owner        <= '0;
         rr_ptr       <= '0;
         core_desc    <= '0;
         lat_cnt      <= '0;
         run_cnt      <= '0;
         last_latency <= '0;
         timeout_err  <= 1'b0;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant     <= NREQ'(1) << pick_idx;
                  owner     <= pick_idx;
                  core_desc <= req_desc[pick_idx*DW +: DW];
                  lat_cnt   <= CW'(1);
               end
            end
            START: begin
               lat_cnt <= sat_inc(lat_cnt);
               run_cnt <= '0;
            end
            RUN: begin
               lat_cnt <= sat_inc(lat_cnt);
               // run_cnt holds the number of earlier RUN cycles; the flag lands after cycle TIMEOUT.
               if (run_cnt == TO_LAST) begin
                  timeout_err <= 1'b1;
               end else begin
                  run_cnt <= run_cnt + 1'b1;
               end
            end
            DONE: begin
               lat_cnt      <= sat_inc(lat_cnt);
               last_latency <= sat_inc(lat_cnt);
               grant        <= '0;
               rr_ptr       <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
            end
            default: ;
         endcase
      end
   end

   a_grant_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(grant));
   a_grant_busy:   assert property (@(posedge clock) disable iff (reset) (grant != '0) == busy);
   a_done_subset:  assert property (@(posedge clock) disable iff (reset) (done & ~grant) == '0);

endmodule

// File: tb/tb_matrixa_job_arbiter.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for matrixa_job_arbiter with a job-level reference model
// and a behavioural ap_ctrl_hs core that answers with configurable ready/done delays.
module tb_matrixa_job_arbiter;

   localparam int NREQ    = 4;
   localparam int DW      = 64;
   localparam int CW      = 16;
   localparam int TIMEOUT = 4096;
   localparam int LMAX    = (1 << CW) - 1;

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic [NREQ-1:0]      req = '0;
   logic [NREQ*DW-1:0]   req_desc = '0;
   logic [NREQ-1:0]      grant;
   logic [NREQ-1:0]      done;
   logic                 core_ap_start;
   logic                 core_ap_ready;
   logic                 core_ap_done;
   logic [DW-1:0]        core_desc;
   logic                 busy;
   logic [CW-1:0]        last_latency;
   logic                 timeout_err;

   always #5 clock = ~clock;

   matrixa_job_arbiter #(.NREQ(NREQ), .DW(DW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
      .clock         (clock),
      .reset         (reset),
      .req           (req),
      .req_desc      (req_desc),
      .grant         (grant),
      .done          (done),
      .core_ap_start (core_ap_start),
      .core_ap_ready (core_ap_ready),
      .core_ap_done  (core_ap_done),
      .core_desc     (core_desc),
      .busy          (busy),
      .last_latency  (last_latency),
      .timeout_err   (timeout_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [NREQ-1:0] vec;
      logic [DW-1:0]   desc;
      logic [CW-1:0]   lat;
   } exp_t;

   exp_t exp_q[$];
   int   jobs_done_seen = 0;

   // Stimulus state
   int              jobs_left [NREQ];
   bit              rand_desc = 0;
   bit              rand_core = 0;
   bit              spurious  = 0;
   int              cfg_rdy   = 0;
   int              cfg_dd    = 0;
   logic [NREQ-1:0] prev_grant = '0;
   logic [NREQ-1:0] grant_log[$];
   int              start_cycles = 0;

   task automatic apply_req();
      for (int i = 0; i < NREQ; i++) req[i] = (jobs_left[i] > 0);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (done[i] && jobs_left[i] > 0) jobs_left[i]--;
      end
      if (grant != '0 && prev_grant == '0) grant_log.push_back(grant);
      prev_grant = grant;
      if (core_ap_start) start_cycles++;
      apply_req();
      if (rand_desc) begin
         for (int i = 0; i < NREQ; i++) req_desc[i*DW +: DW] = {$urandom, $urandom};
      end
   endtask

   task automatic wait_quiet(input int budget);
      int  n;
      bit  pending;
      n = 0;
      do begin
         step();
         n++;
         pending = busy;
         for (int i = 0; i < NREQ; i++) if (jobs_left[i] > 0) pending = 1;
      end while (pending && n < budget);
      checks++;
      if (pending) begin
         errors++;
         $display("FAIL wait_quiet: still busy after %0d cycles, want idle", n);
      end
      step();
   endtask

   task automatic clear_jobs();
      for (int i = 0; i < NREQ; i++) jobs_left[i] = 0;
      apply_req();
   endtask

   // Behavioural core: ready rd cycles after ap_start is first seen, done dd cycles after ready.
   initial begin : core_model
      bit started;
      int k, rd, dd;
      started = 0; k = 0; rd = 0; dd = 0;
      core_ap_ready = 1'b0;
      core_ap_done  = 1'b0;
      forever begin
         @(posedge clock);
         #2;
         core_ap_ready = 1'b0;
         core_ap_done  = 1'b0;
         if (reset) begin
            started = 0;
         end else if (started || core_ap_start) begin
            if (!started) begin
               started = 1;
               k = 0;
               rd = rand_core ? int'($urandom_range(0, 3)) : cfg_rdy;
               dd = rand_core ? int'($urandom_range(0, 6)) : cfg_dd;
            end
            if (k == rd) core_ap_ready = 1'b1;
            if (k == rd + dd) begin
               core_ap_done = 1'b1;
               started = 0;
            end
            k++;
         end else if (spurious && !busy && $urandom_range(0, 5) == 0) begin
            core_ap_ready = 1'($urandom_range(0, 1));
            core_ap_done  = 1'($urandom_range(0, 1));
         end
      end
   end

   // Job-level reference: free -> owns core -> completion cycle -> free.
   typedef enum {M_IDLE, M_ACTIVE, M_FINISH} mst_t;
   mst_t            m_state = M_IDLE;
   int              m_ptr   = 0;
   int              m_owner = 0;
   logic [DW-1:0]   m_desc  = '0;
   int              m_lat   = 0;
   int              m_run   = 0;
   bit              m_ready = 0;
   bit              m_to    = 0;

   function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
      for (int i = 0; i < NREQ; i++) begin
         if (r[(p + i) % NREQ]) return (p + i) % NREQ;
      end
      return -1;
   endfunction

   initial begin : ref_model
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset) begin
            m_state = M_IDLE;
            m_ptr   = 0;
            m_to    = 0;
            exp_q.delete();
         end else begin
            check("timeout_err", 64'(timeout_err), 64'(m_to));
            case (m_state)
               M_IDLE: begin
                  check("idle_outputs", 64'({grant, done, busy, core_ap_start}), 64'(0));
                  if (req != '0) begin
                     m_owner = rr_pick(req, m_ptr);
                     m_desc  = req_desc[m_owner*DW +: DW];
                     m_lat   = 1;
                     m_run   = 0;
                     m_ready = 0;
                     m_state = M_ACTIVE;
                  end
               end
               M_ACTIVE: begin
                  check("grant", 64'(grant), 64'(1) << m_owner);
                  check("core_desc", 64'(core_desc), 64'(m_desc));
                  check("ap_start", 64'(core_ap_start), 64'(!m_ready));
                  check("busy_done", 64'({busy, done}), 64'({1'b1, {NREQ{1'b0}}}));
                  m_lat = (m_lat + 1 > LMAX) ? LMAX : m_lat + 1;
                  if (m_ready) begin
                     m_run++;
                     if (m_run >= TIMEOUT) m_to = 1;
                  end
                  if (!m_ready && core_ap_ready) m_ready = 1;
                  if (m_ready && core_ap_done) begin
                     e.vec  = NREQ'(1) << m_owner;
                     e.desc = m_desc;
                     e.lat  = CW'((m_lat + 1 > LMAX) ? LMAX : m_lat + 1);
                     exp_q.push_back(e);
                     m_state = M_FINISH;
                  end
               end
               M_FINISH: begin
                  check("finish_state", 64'({busy, core_ap_start}), 64'(2'b10));
                  m_ptr   = (m_owner + 1) % NREQ;
                  m_state = M_IDLE;
               end
               default: m_state = M_IDLE;
            endcase
         end
      end
   end

   // Monitor: pops the scoreboard whenever a done pulse appears.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset && done != '0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got %b, want no pulse", done);
            end else begin
               e = exp_q.pop_front();
               jobs_done_seen++;
               check("done_vec", 64'(done), 64'(e.vec));
               check("done_desc", 64'(core_desc), 64'(e.desc));
               @(negedge clock);
               if (!reset) begin
                  check("last_latency", 64'(last_latency), 64'(e.lat));
                  check("done_one_cycle", 64'(done), 64'(0));
               end
            end
         end
      end
   end

   task automatic do_reset();
      clear_jobs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   initial begin : main
      int base, n, owner, added;
      logic [DW-1:0] orig;
      for (int i = 0; i < NREQ; i++) jobs_left[i] = 0;

      // Reset values
      reset = 1'b1;
      repeat (3) step();
      check("rst_grant", 64'(grant), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_ap_start", 64'(core_ap_start), 64'(0));
      check("rst_core_desc", 64'(core_desc), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_last_latency", 64'(last_latency), 64'(0));
      check("rst_timeout_err", 64'(timeout_err), 64'(0));
      reset = 1'b0;
      step();

      // Single requester 2, ready 1 cycle after start, done 5 cycles after start
      cfg_rdy = 1; cfg_dd = 4;
      base = jobs_done_seen;
      req_desc[2*DW +: DW] = 64'hA5;
      jobs_left[2] = 1;
      apply_req();
      step();
      check("t1_grant", 64'(grant), 64'(4'b0100));
      check("t1_core_desc", 64'(core_desc), 64'hA5);
      wait_quiet(100);
      check("t1_last_latency", 64'(last_latency), 64'd8);
      check("t1_done_count", 64'(jobs_done_seen - base), 64'd1);

      // All four requesting for eight jobs
      do_reset();
      cfg_rdy = 1; cfg_dd = 2;
      grant_log.delete();
      for (int i = 0; i < NREQ; i++) jobs_left[i] = 2;
      apply_req();
      wait_quiet(300);
      check("rr_count", 64'(grant_log.size()), 64'd8);
      for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
         check("rr_order", 64'(grant_log[i]), 64'(1) << (i % NREQ));
      end

      // Single-beat core
      cfg_rdy = 0; cfg_dd = 0;
      start_cycles = 0;
      jobs_left[1] = 1;
      apply_req();
      wait_quiet(50);
      check("sb_last_latency", 64'(last_latency), 64'd3);
      check("sb_ap_start_cycles", 64'(start_cycles), 64'd1);

      // Owner drops req one cycle after grant and its descriptor changes
      cfg_rdy = 2; cfg_dd = 6;
      grant_log.delete();
      base = jobs_done_seen;
      req_desc[0*DW +: DW] = 64'h0123_4567_89AB_CDEF;
      req_desc[3*DW +: DW] = 64'hFEDC_BA98_7654_3210;
      jobs_left[0] = 1; jobs_left[3] = 1;
      apply_req();
      n = 0;
      do begin step(); n++; end while (grant == '0 && n < 20);
      owner = 0;
      for (int i = 0; i < NREQ; i++) if (grant[i]) owner = i;
      orig = core_desc;
      step();
      jobs_left[owner] = 0;
      req_desc[owner*DW +: DW] = ~orig;
      apply_req();
      repeat (3) step();
      check("drop_core_desc", 64'(core_desc), 64'(orig));
      wait_quiet(200);
      check("drop_done_count", 64'(jobs_done_seen - base), 64'd2);
      check("drop_grant_count", 64'(grant_log.size()), 64'd2);
      if (grant_log.size() == 2) begin
         check("drop_first", 64'(grant_log[0]), 64'(4'b1000));
         check("drop_second", 64'(grant_log[1]), 64'(4'b0001));
      end

      // Randomized traffic, random core delays, spurious ready/done while idle
      rand_core = 1; rand_desc = 1; spurious = 1;
      added = 0;
      for (int c = 0; c < 600 && added < 40; c++) begin
         step();
         if ($urandom_range(0, 3) == 0) begin
            n = int'($urandom_range(0, NREQ - 1));
            if (jobs_left[n] < 2) begin
               jobs_left[n]++;
               added++;
               apply_req();
            end
         end
      end
      wait_quiet(2000);
      rand_core = 0; rand_desc = 0; spurious = 0;

      // Timeout: done held off 5000 RUN cycles
      cfg_rdy = 1; cfg_dd = 5000;
      jobs_left[2] = 1;
      apply_req();
      n = 0;
      do begin step(); n++; end while (!(busy && !core_ap_start) && n < 20);
      repeat (TIMEOUT - 1) step();
      check("to_before", 64'(timeout_err), 64'(0));
      step();
      check("to_after", 64'(timeout_err), 64'(1));
      wait_quiet(2000);
      check("to_sticky", 64'(timeout_err), 64'(1));
      check("to_last_latency", 64'(last_latency), 64'd5004);

      // Reset in RUN with grant 4'b0010, after a job has moved rr_ptr past requester 1
      cfg_rdy = 1; cfg_dd = 2;
      jobs_left[1] = 1;
      apply_req();
      wait_quiet(50);
      cfg_dd = 50;
      jobs_left[1] = 1;
      apply_req();
      n = 0;
      do begin step(); n++; end while (!(busy && !core_ap_start) && n < 20);
      check("mid_grant", 64'(grant), 64'(4'b0010));
      base = jobs_done_seen;
      clear_jobs();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_state", 64'({grant, done, busy, timeout_err}), 64'(0));
      repeat (5) step();
      check("mid_rst_no_done", 64'(jobs_done_seen - base), 64'd0);
      cfg_dd = 3;
      grant_log.delete();
      jobs_left[1] = 1; jobs_left[3] = 1;
      apply_req();
      wait_quiet(200);
      check("post_rst_grants", 64'(grant_log.size()), 64'd2);
      if (grant_log.size() == 2) begin
         check("post_rst_first", 64'(grant_log[0]), 64'(4'b0010));
         check("post_rst_second", 64'(grant_log[1]), 64'(4'b1000));
      end

      repeat (3) step();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/matrixa_job_arbiter.md
Name: matrixa_job_arbiter

Overview:
- Round-robin scheduler that shares one HLS `matrixa` matrix-adder core (ap_ctrl_hs: ap_start/ap_ready/ap_done, ap_continue tied high) between NREQ requesters.
- Each requester presents a packed job descriptor (operand/result base addresses, dimensions). The block grants one job at a time, drives the core's ap_start handshake and routes ap_done back to the owner as a one-cycle done pulse.
- Also reports per-job latency and a sticky timeout flag for the dataflow monitors and the testbench.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 64, job descriptor width in bits
- CW, 16, latency counter width
- TIMEOUT, 4096, RUN-state cycle limit before timeout_err is set (must be < 2^CW)

Ports:
- clock  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester job request, level, held until that requester's done bit
- req_desc  in  NREQ*DW  packed descriptors, requester i at bits [i*DW +: DW]
- grant  out  NREQ  one-hot owner of the core, held from grant to done
- done  out  NREQ  one-hot, one-cycle pulse to the owner at job completion
- core_ap_start  out  1  to core ap_start
- core_ap_ready  in  1  from core ap_ready
- core_ap_done  in  1  from core ap_done
- core_desc  out  DW  descriptor to the core's scalar arguments, stable while grant != 0
- busy  out  1  high in any state other than IDLE
- last_latency  out  CW  cycles from grant to done for the last completed job, saturating
- timeout_err  out  1  sticky; set when RUN lasts TIMEOUT cycles

Behaviour:
- Reset values: grant=0, done=0, core_ap_start=0, core_desc=0, busy=0, last_latency=0, timeout_err=0, rr_ptr=0, state=IDLE. Reset mid-job returns to IDLE at once with no done pulse. The core is reset by the same signal.
- FSM has four states: IDLE, START, RUN and DONE.
- IDLE
  - If req != 0, choose the first set bit searching from rr_ptr upward, with modulo-NREQ wrap.
  - Register grant (one-hot) and core_desc = that requester's slice. Clear lat_cnt to 1. Go to START.
  - If req = 0, stay in IDLE.
- START
  - core_ap_start=1, held until core_ap_ready is sampled high.
  - ap_ready high and ap_done low in the same cycle: go to RUN, and drop ap_start in the next cycle.
  - ap_ready and ap_done both high in the same cycle (single-beat core): go straight to DONE.
- RUN
  - core_ap_start=0. Wait for core_ap_done, then go to DONE.
  - The timeout counter counts RUN cycles. When it reaches TIMEOUT, set timeout_err, which stays set until reset. The FSM keeps waiting; there is no abort.
- DONE (exactly one cycle)
  - done = grant (pulse). last_latency = lat_cnt.
  - grant clears at the end of the cycle. rr_ptr = owner index + 1 mod NREQ. Go to IDLE.
- Timing and latency
  - lat_cnt increments every cycle from the grant cycle through DONE and saturates at 2^CW-1.
  - Minimum job turnaround is 3 cycles: IDLE grant, START with ready+done, DONE.
  - No back-to-back grant in the DONE cycle. The next arbitration happens in the following IDLE cycle, so there is 1 dead cycle between jobs.
- Request handling
  - req changes for non-owners are ignored until IDLE.
  - The owner dropping req mid-job does not abort; done still pulses.
  - The owner's req_desc may change after grant without effect, because core_desc is registered.
- Fairness: with all req bits high, grants rotate 0,1,2,...,NREQ-1,0. A requester waits at most NREQ-1 jobs.
- core_ap_done or core_ap_ready arriving in IDLE is ignored.

Test Plan:
- Single requester, NREQ=4: req=4'b0100, desc=64'hA5; core ready 1 cycle after start, done 5 cycles later -> grant=4'b0100, core_desc=64'hA5, done[2] pulses once, last_latency=8.
- All four requesting continuously for 8 jobs -> grant order 0,1,2,3,0,1,2,3; one idle cycle between each done and the next grant.
- Single-beat core: ap_ready and ap_done high in the same cycle as the first ap_start -> START->DONE directly, ap_start high 1 cycle, last_latency=3.
- Core holds ap_done low 5000 cycles with TIMEOUT=4096 -> timeout_err rises on RUN cycle 4096 and stays high; done pulses when ap_done finally arrives; last_latency saturates only if past 65535.
- Reset asserted in RUN with grant=4'b0010 -> next cycle grant=0, busy=0, no done pulse, timeout_err=0, rr_ptr=0; next request from requester 3 is granted normally.
- Owner drops req one cycle after grant and req_desc changes -> core_desc keeps its original value, done for that owner still pulses, next grant goes to the next requester in round-robin order.
